enc8x3_seq: RTL

- Sequential 8-to-3 encoder; the inverse of the team's 3x8 decoder.
- Captures an 8-bit one-hot/multi-hot word `I` on enable `e`.
- Emits the 3-bit index of every set bit, one per accepted handshake, in priority order.
- Sits between request/select lines and any consumer that needs the binary code (A,B,C) back, e.g. a round-trip decoder→encoder check in the lab datapath.

---
 rtl/enc8x3_seq.sv | 111 +++++++++++
 1 files changed

// File: rtl/enc8x3_seq.sv
// Sequential 8-to-3 encoder: captures a request word and emits one 3-bit index per handshake, in priority order.
// First code is valid 1 clock after capture, then one code per clock. While ready=0 the code holds, and capture is ignored while busy.
module enc8x3_seq #(
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       e,
  input  logic [0:7] I,
  input  logic       ready,
  output logic [2:0] code,
  output logic       valid,
  output logic       last,
  output logic       busy,
  output logic       zero
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [0:7] pend_q, pend_d;
  logic       zero_q, zero_d;
  logic [2:0] sel;
  logic [3:0] pend_cnt;

  // Index of the highest-priority pending bit; later matches in the loop win.
  function automatic logic [2:0] pick(input logic [0:7] p);
    logic [2:0] idx;
    idx = 3'd0;
    if (LSB_FIRST) begin
      for (int k = 7; k >= 0; k--) begin
        if (p[k]) idx = 3'(k);
      end
    end else begin
      for (int k = 0; k < 8; k++) begin
        if (p[k]) idx = 3'(k);
      end
    end
    return idx;
  endfunction

  function automatic logic [3:0] ones(input logic [0:7] p);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < 8; k++) begin
      n = n + {3'd0, p[k]};
    end
    return n;
  endfunction

  always_comb begin
    sel      = pick(pend_q);
    pend_cnt = ones(pend_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      zero_q  <= zero_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    zero_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (e) begin
          if (I != '0) begin
            pend_d  = I;
            state_d = SCAN;
          end else begin
            zero_d = 1'b1;
          end
        end
      end
      SCAN: begin
        // e and I are deliberately not looked at here: captures during a scan are dropped.
        if (ready) begin
          pend_d[sel] = 1'b0;
          if (pend_cnt == 4'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    valid = 1'b0;
    busy  = 1'b0;
    code  = 3'd0;
    last  = 1'b0;
    if (state_q == SCAN) begin
      valid = 1'b1;
      busy  = 1'b1;
      code  = sel;
      last  = (pend_cnt == 4'd1);
    end
    zero = zero_q;
  end

endmodule
